lz_normalizer: RTL and testbench

- Pipelined normalizer that sits directly downstream of the leading-zero counter.
- Takes a raw data word together with its leading-zero count and left-shifts the word so its MSB is 1.
- Emits the normalized mantissa, the applied shift, a zero flag and a count-consistency error flag.
- Valid/ready handshakes on both sides; throughput one word per cycle; fixed two-stage latency.

---
 rtl/lz_normalizer.sv | 131 +++++++++++++
 tb/tb_lz_normalizer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/lz_normalizer.sv
// Two-stage normalizer behind a leading-zero counter: S1 registers the word and
// checks the supplied count, S2 left-justifies the word through a log shifter.

module lz_shift_stage #(
  parameter int WIDTH = 16,
  parameter int AMT   = 1
) (
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  output logic [WIDTH-1:0] q
);
  generate
    if (AMT >= WIDTH) begin : g_flush
      assign q = en ? '0 : d;
    end else begin : g_shift
      assign q = en ? {d[WIDTH-1-AMT:0], {AMT{1'b0}}} : d;
    end
  endgenerate
endmodule

module lz_normalizer #(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [$clog2(WIDTH):0] in_lz,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_mant,
  output logic [$clog2(WIDTH):0] out_shift,
  output logic                   out_zero,
  output logic                   out_lz_err
);
  localparam int LW     = $clog2(WIDTH) + 1;
  localparam int STAGES = 2;
  localparam logic [LW-1:0] W_C = LW'(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [LW-1:0]    lz;
    logic             err;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] mant;
    logic [LW-1:0]    shift;
    logic             zero;
    logic             err;
  } rsp_t;

  logic [STAGES:1] vld_pipe;
  s1_t             s1, s1_nxt;
  rsp_t            s2, s2_nxt;
  logic            s1_adv, s2_adv;

  assign s2_adv   = !vld_pipe[2] || out_ready;
  assign s1_adv   = !vld_pipe[1] || s2_adv;
  assign in_ready = s1_adv;

  // Count check: the top in_lz bits must be clear and the next bit must be set.
  logic [WIDTH-1:0] hi_mask, lz_shl;
  logic             lz_over, lz_full;

  always_comb begin
    hi_mask = ~({WIDTH{1'b1}} >> in_lz);
    lz_shl  = in_data << in_lz;
    lz_over = in_lz > W_C;
    lz_full = in_lz == W_C;
    s1_nxt.data = in_data;
    s1_nxt.lz   = in_lz;
    s1_nxt.err  = lz_over || (|(in_data & hi_mask)) ||
                  (!lz_over && !lz_full && !lz_shl[WIDTH-1]);
  end

  logic [LW-1:0]             sh;
  logic                      zero;
  logic [LW:0][WIDTH-1:0]    stg;

  always_comb begin
    zero = (s1.data == '0);
    if (zero)             sh = W_C;
    else if (s1.lz > W_C) sh = W_C;
    else                  sh = s1.lz;
  end

  assign stg[0] = s1.data;

  genvar k;
  generate
    for (k = 0; k < LW; k++) begin : g_stage
      lz_shift_stage #(.WIDTH(WIDTH), .AMT(1 << k)) u_stage (
        .d  (stg[k]),
        .en (sh[k]),
        .q  (stg[k+1])
      );
    end
  endgenerate

  always_comb begin
    s2_nxt.mant  = zero ? '0 : stg[LW];
    s2_nxt.shift = sh;
    s2_nxt.zero  = zero;
    s2_nxt.err   = s1.err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
    end else begin
      if (s1_adv) begin
        vld_pipe[1] <= in_valid;
        s1          <= s1_nxt;
      end
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        s2          <= s2_nxt;
      end
    end
  end

  assign out_valid  = vld_pipe[2];
  assign out_mant   = s2.mant;
  assign out_shift  = s2.shift;
  assign out_zero   = s2.zero;
  assign out_lz_err = s2.err;
endmodule

// File: tb/tb_lz_normalizer.sv
// Scoreboard bench for lz_normalizer: directed cases, backpressure, reset and
// randomized traffic checked against an arithmetic reference model.

module tb_lz_normalizer;
  localparam int W  = 8;
  localparam int LW = $clog2(W) + 1;

  logic          clk, rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_data, out_mant;
  logic [LW-1:0] in_lz, out_shift;
  logic          out_zero, out_lz_err;

  lz_normalizer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_lz(in_lz),
    .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant),
    .out_shift(out_shift), .out_zero(out_zero), .out_lz_err(out_lz_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  mant;
    logic [LW-1:0] shift;
    logic          zero;
    logic          err;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   rnd_mode = 0;

  // Reference: count true leading zeros, flag any disagreement, shift by multiplication.
  function automatic exp_t model(input logic [W-1:0] d, input logic [LW-1:0] lz);
    exp_t e;
    int t = 0;
    int s;
    while (t < W && d[W-1-t] == 1'b0) t++;
    e.zero  = (d == 0);
    s       = e.zero ? W : ((int'(lz) > W) ? W : int'(lz));
    e.shift = LW'(s);
    e.mant  = e.zero ? '0 : W'((int'(d) * (1 << s)) % (1 << W));
    e.err   = (int'(lz) != t);
    return e;
  endfunction

  // Monitor: decoupled from stimulus, sees transfers at the falling edge.
  exp_t held;
  bit   stalled = 0;
  always @(negedge clk) begin
    exp_t got, e;
    got = {out_mant, out_shift, out_zero, out_lz_err};
    if (rst) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        vectors++;
        if (got !== held) begin
          miscompares++;
          $display("FAIL stall_hold got %h want %h", got, held);
        end
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_output got %h want none", got);
        end else begin
          e = q.pop_front();
          if (got !== e) begin
            miscompares++;
            $display("FAIL output got mant=%h shift=%0d zero=%0d err=%0d want mant=%h shift=%0d zero=%0d err=%0d",
                     got.mant, got.shift, got.zero, got.err, e.mant, e.shift, e.zero, e.err);
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_data, in_lz));
      stalled = out_valid && !out_ready;
      held    = got;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [W-1:0] d, input logic [LW-1:0] lz);
    bit acc = 0;
    int n = 0;
    in_data = d; in_lz = lz; in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  // Pipe empty and out_ready high: result visible exactly one edge after S1 load.
  task automatic send_lat(input logic [W-1:0] d, input logic [LW-1:0] lz,
                          input int m, input int s, input int z, input int e);
    send(d, lz);
    @(negedge clk); chk("lat_early_valid", int'(out_valid), 0);
    @(negedge clk);
    chk("lat_valid", int'(out_valid), 1);
    chk("lat_mant",  int'(out_mant), m);
    chk("lat_shift", int'(out_shift), s);
    chk("lat_zero",  int'(out_zero), z);
    chk("lat_err",   int'(out_lz_err), e);
    @(negedge clk); chk("single_cycle_valid", int'(out_valid), 0);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin tick(); n++; end
    chk("drain_left", q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_lz = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_mant",  int'(out_mant), 0);
    chk("rst_out_shift", int'(out_shift), 0);
    chk("rst_out_zero",  int'(out_zero), 0);
    chk("rst_out_err",   int'(out_lz_err), 0);
    chk("rst_in_ready",  int'(in_ready), 1);

    out_ready = 1'b1;
    send_lat(8'h16, 4'd3, 8'hB0, 3, 0, 0);
    send_lat(8'h00, 4'd8, 8'h00, 8, 1, 0);
    send_lat(8'h80, 4'd0, 8'h80, 0, 0, 0);
    send_lat(8'h16, 4'd2, 8'h58, 2, 0, 1);
    send_lat(8'h00, 4'd9, 8'h00, 8, 1, 1);

    // Backpressure: two words fill the pipe, the third waits.
    out_ready = 1'b0;
    send(8'h01, 4'd7);
    send(8'h02, 4'd6);
    in_data = 8'h04; in_lz = 4'd5; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk); chk("full_in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
    end
    chk("full_out_valid", int'(out_valid), 1);
    chk("full_queue", q.size(), 2);
    out_ready = 1'b1;
    send(8'h04, 4'd5);
    send(8'h08, 4'd4);
    drain();

    // Reset with two words in flight.
    out_ready = 1'b0;
    send(8'h40, 4'd1);
    send(8'h20, 4'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready",  int'(in_ready), 1);
    out_ready = 1'b1;
    send_lat(8'h16, 4'd3, 8'hB0, 3, 0, 0);

    // Randomized traffic with random backpressure and occasional bad counts.
    rnd_mode = 1;
    for (int i = 0; i < 400; i++) begin
      int t = $urandom_range(0, W);
      logic [W-1:0] d;
      logic [LW-1:0] lz;
      if (t == W) d = '0;
      else d = W'((1 << (W-1-t)) | ($urandom & ((1 << (W-1-t)) - 1)));
      lz = LW'(t);
      if ($urandom_range(0, 3) == 0) lz = LW'($urandom_range(0, (1 << LW) - 1));
      send(d, lz);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
    end
    rnd_mode = 0;
    out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
